// File: rtl/proc_pkg.sv
// Shared pipeline definitions: opcodes, bubble encoding and memory-stage FSM states.
package proc_pkg;

   localparam logic [4:0]  OP_LW = 5'b01000;
   localparam logic [4:0]  OP_SW = 5'b00111;
   localparam logic [31:0] NOP   = 32'h0000_0000;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

endpackage

// File: rtl/dff_cell.sv
// Single-bit D flip-flop with asynchronous active-low clear; base cell for pipeline registers.
module dff_cell (
   input  logic clk,
   input  logic clear,
   input  logic d,
   output logic q
);

   // one bit of pipeline state, zeroed on clear
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) q <= 1'b0;
      else        q <= d;
   end

endmodule

// File: rtl/mw_reg.sv
// M/W pipeline register: ALU result, load data and instruction, 32 bits each.
module mw_reg (
   input  logic        clk,
   input  logic        clear,
   input  logic [31:0] o_in,
   input  logic [31:0] d_in,
   input  logic [31:0] ir_in,
   output logic [31:0] o_out,
   output logic [31:0] d_out,
   output logic [31:0] ir_out
);

   logic [95:0] d_bus;
   logic [95:0] q_bus;

   assign d_bus = {o_in, d_in, ir_in};

   for (genvar i = 0; i < 96; i++) begin : g_bit
      dff_cell u_dff (
         .clk   (clk),
         .clear (clear),
         .d     (d_bus[i]),
         .q     (q_bus[i])
      );
   end

   assign o_out  = q_bus[95:64];
   assign d_out  = q_bus[63:32];
   assign ir_out = q_bus[31:0];

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: runs a req/ack data-memory transaction for lw/sw,
// stalls upstream while waiting, aborts after TIMEOUT wait cycles, and
// feeds the M/W register with the stage result or a bubble.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transaction; pass-through ops flow, lw/sw start a request
// WAIT  | request outstanding; waiting for dmem_ack or timeout
module mem_stage
   import proc_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              clear,
   input  logic [31:0]       o_in,
   input  logic [31:0]       b_in,
   input  logic [31:0]       ir_in,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic [31:0]       dmem_rdata,
   input  logic              dmem_ack,
   output logic              stall,
   output logic [31:0]       o_out,
   output logic [31:0]       d_out,
   output logic [31:0]       ir_out,
   output logic              mem_err
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   mem_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [4:0]       op;
   logic             is_mem;
   logic             start, done_ack, abort;
   logic [31:0]      mw_o, mw_d, mw_ir;

   assign op     = ir_in[31:27];
   assign is_mem = (op == OP_LW) || (op == OP_SW);

   // state register
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state: an ack in the final wait cycle completes normally
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (is_mem) state_nxt = WAIT;
         WAIT:    if (dmem_ack || (cnt == CNT_LAST)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // outputs: stall, M/W input selection and transaction events
   always_comb begin
      stall    = 1'b0;
      mw_o     = o_in;
      mw_d     = NOP;
      mw_ir    = ir_in;
      start    = 1'b0;
      done_ack = 1'b0;
      abort    = 1'b0;
      case (state)
         IDLE: begin
            if (is_mem) begin
               stall = 1'b1;
               mw_o  = NOP;
               mw_ir = NOP;
               start = 1'b1;
            end
         end
         WAIT: begin
            if (dmem_ack) begin
               done_ack = 1'b1;
               mw_d     = dmem_we ? NOP : dmem_rdata;
            end else if (cnt == CNT_LAST) begin
               abort = 1'b1;
            end else begin
               stall = 1'b1;
               mw_o  = NOP;
               mw_ir = NOP;
            end
         end
         default: ;
      endcase
   end

   // request registers, wait counter and sticky error flag
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         cnt        <= '0;
         mem_err    <= 1'b0;
      end else begin
         if (start) begin
            dmem_req   <= 1'b1;
            dmem_we    <= (op == OP_SW);
            dmem_addr  <= o_in[ADDR_W-1:0];
            dmem_wdata <= b_in;
            cnt        <= '0;
         end else if (done_ack || abort) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
         end else if (state == WAIT) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (abort) mem_err <= 1'b1;
      end
   end

   mw_reg u_mw_reg (
      .clk    (clk),
      .clear  (clear),
      .o_in   (mw_o),
      .d_in   (mw_d),
      .ir_in  (mw_ir),
      .o_out  (o_out),
      .d_out  (d_out),
      .ir_out (ir_out)
   );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: per-cycle reference model feeding a
// scoreboard of expected M/W contents, a vector table of operations with
// expected stall/request counts and results, and a reset-mid-WAIT sequence.
module tb_mem_stage;

   localparam int ADDR_W  = 12;
   localparam int TIMEOUT = 15;

   localparam logic [31:0] I_ADD  = 32'h0000_0020;
   localparam logic [31:0] I_LW   = 32'h4123_0004;
   localparam logic [31:0] I_SW   = 32'h3845_0008;
   localparam logic [31:0] I_OTH  = 32'h4800_0000;

   logic              clk = 1'b0;
   logic              clear;
   logic [31:0]       o_in, b_in, ir_in;
   logic              dmem_req, dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [31:0]       dmem_wdata, dmem_rdata;
   logic              dmem_ack;
   logic              stall;
   logic [31:0]       o_out, d_out, ir_out;
   logic              mem_err;

   mem_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .clear      (clear),
      .o_in       (o_in),
      .b_in       (b_in),
      .ir_in      (ir_in),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata),
      .dmem_ack   (dmem_ack),
      .stall      (stall),
      .o_out      (o_out),
      .d_out      (d_out),
      .ir_out     (ir_out),
      .mem_err    (mem_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] o, d, ir;
   } mw_t;

   typedef struct {
      logic [31:0] ir;
      logic [31:0] o;
      logic [31:0] b;
      logic [31:0] rdata;
      int          ack_at;      // WAIT cycle (1-based) carrying the ack, 0 = never
      int          exp_stalls;
      int          exp_reqs;
      logic [31:0] exp_d;
      logic        exp_err;
   } vec_t;

   mw_t  sb[$];
   vec_t vecs[10];

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic              m_wait = 1'b0;
   int                m_cnt  = 0;
   logic              m_we   = 1'b0;
   logic [ADDR_W-1:0] m_addr = '0;
   logic [31:0]       m_wdata = '0;
   logic              m_err  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock cycle; entered #1 after a rising edge with o/b/ir already driven.
   task automatic step(input logic ack, input logic [31:0] rdata, output logic st);
      logic [4:0] op;
      logic       is_mem;
      logic       e_stall;
      mw_t        e, got;
      dmem_ack   = ack;
      dmem_rdata = ack ? rdata : $urandom;
      #3;
      op     = ir_in[31:27];
      is_mem = (op == 5'b01000) || (op == 5'b00111);
      e = '{o: o_in, d: 32'h0, ir: ir_in};
      if (!m_wait) begin
         if (is_mem) begin
            e_stall = 1'b1;
            e       = '{o: 32'h0, d: 32'h0, ir: 32'h0};
            m_wait  = 1'b1;
            m_cnt   = 0;
            m_we    = (op == 5'b00111);
            m_addr  = o_in[ADDR_W-1:0];
            m_wdata = b_in;
         end else begin
            e_stall = 1'b0;
         end
      end else if (ack) begin
         e_stall = 1'b0;
         e.d     = m_we ? 32'h0 : rdata;
         m_wait  = 1'b0;
      end else if (m_cnt == TIMEOUT - 1) begin
         e_stall = 1'b0;
         m_err   = 1'b1;
         m_wait  = 1'b0;
      end else begin
         e_stall = 1'b1;
         e       = '{o: 32'h0, d: 32'h0, ir: 32'h0};
         m_cnt++;
      end
      sb.push_back(e);
      st = stall;
      chk("stall", {31'h0, stall}, {31'h0, e_stall});
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
      got = '{o: o_out, d: d_out, ir: ir_out};
      e   = sb.pop_front();
      chk("mw_o_out", got.o, e.o);
      chk("mw_d_out", got.d, e.d);
      chk("mw_ir_out", got.ir, e.ir);
      chk("dmem_req", {31'h0, dmem_req}, {31'h0, m_wait});
      chk("mem_err", {31'h0, mem_err}, {31'h0, m_err});
      if (m_wait) begin
         chk("dmem_we", {31'h0, dmem_we}, {31'h0, m_we});
         chk("dmem_addr", {20'h0, dmem_addr}, {20'h0, m_addr});
         chk("dmem_wdata", dmem_wdata, m_wdata);
      end
   endtask

   task automatic run_op(input vec_t v, output int stalls, output int reqs);
      logic st;
      logic ack;
      int   wc;
      logic done;
      ir_in  = v.ir;
      o_in   = v.o;
      b_in   = v.b;
      wc     = 0;
      stalls = 0;
      reqs   = 0;
      done   = 1'b0;
      chk("req_low_at_issue", {31'h0, dmem_req}, 32'h0);
      for (int c = 0; c < 40 && !done; c++) begin
         if (m_wait) wc++;
         ack = m_wait && (wc == v.ack_at);
         if (dmem_req) reqs++;
         step(ack, v.rdata, st);
         if (st) stalls++;
         else    done = 1'b1;
      end
      if (!done) chk("op_cycle_budget", 32'h0, 32'h1);
   endtask

   initial begin
      int   stalls, reqs;
      logic st;

      vecs[0] = '{ir: I_ADD, o: 32'h5,      b: 32'h0,    rdata: 32'h0,        ack_at: 0,  exp_stalls: 0,  exp_reqs: 0,  exp_d: 32'h0,        exp_err: 1'b0};
      vecs[1] = '{ir: I_LW,  o: 32'h40,     b: 32'h0,    rdata: 32'hDEADBEEF, ack_at: 3,  exp_stalls: 3,  exp_reqs: 3,  exp_d: 32'hDEADBEEF, exp_err: 1'b0};
      vecs[2] = '{ir: I_SW,  o: 32'h10,     b: 32'h1234, rdata: 32'hFFFF0000, ack_at: 1,  exp_stalls: 1,  exp_reqs: 1,  exp_d: 32'h0,        exp_err: 1'b0};
      vecs[3] = '{ir: I_LW,  o: 32'h0001FFF, b: 32'h0,   rdata: 32'hA5A5_5A5A, ack_at: 2, exp_stalls: 2,  exp_reqs: 2,  exp_d: 32'hA5A5_5A5A, exp_err: 1'b0};
      vecs[4] = '{ir: I_OTH, o: 32'h77,     b: 32'h9,    rdata: 32'h0,        ack_at: 0,  exp_stalls: 0,  exp_reqs: 0,  exp_d: 32'h0,        exp_err: 1'b0};
      vecs[5] = '{ir: I_LW,  o: 32'h123,    b: 32'h0,    rdata: 32'hCAFE_F00D, ack_at: 15, exp_stalls: 15, exp_reqs: 15, exp_d: 32'hCAFE_F00D, exp_err: 1'b0};
      vecs[6] = '{ir: I_SW,  o: 32'h200,    b: 32'h5555, rdata: 32'h0,        ack_at: 1,  exp_stalls: 1,  exp_reqs: 1,  exp_d: 32'h0,        exp_err: 1'b0};
      vecs[7] = '{ir: I_LW,  o: 32'h300,    b: 32'h0,    rdata: 32'h0BAD_0BAD, ack_at: 0,  exp_stalls: 15, exp_reqs: 15, exp_d: 32'h0,        exp_err: 1'b1};
      vecs[8] = '{ir: I_ADD, o: 32'h7,      b: 32'h0,    rdata: 32'h0,        ack_at: 0,  exp_stalls: 0,  exp_reqs: 0,  exp_d: 32'h0,        exp_err: 1'b1};
      vecs[9] = '{ir: I_LW,  o: 32'h44,     b: 32'h0,    rdata: 32'h1111_2222, ack_at: 1, exp_stalls: 1,  exp_reqs: 1,  exp_d: 32'h1111_2222, exp_err: 1'b1};

      clear      = 1'b0;
      o_in       = 32'h0;
      b_in       = 32'h0;
      ir_in      = 32'h0;
      dmem_rdata = 32'h0;
      dmem_ack   = 1'b0;
      #12;
      chk("rst_dmem_req", {31'h0, dmem_req}, 32'h0);
      chk("rst_stall", {31'h0, stall}, 32'h0);
      chk("rst_outputs", o_out | d_out | ir_out, 32'h0);
      chk("rst_mem_err", {31'h0, mem_err}, 32'h0);
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk);
      #1;

      // reset in the middle of a WAIT
      ir_in = I_LW;
      o_in  = 32'h80;
      b_in  = 32'h0;
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, st);
      chk("midwait_req_before", {31'h0, dmem_req}, 32'h1);
      #2;
      clear = 1'b0;
      #1;
      chk("midwait_req_dropped", {31'h0, dmem_req}, 32'h0);
      chk("midwait_outputs", o_out | d_out | ir_out | dmem_wdata, 32'h0);
      chk("midwait_addr", {20'h0, dmem_addr}, 32'h0);
      m_wait = 1'b0;
      m_cnt  = 0;
      m_err  = 1'b0;
      ir_in  = I_ADD;
      o_in   = 32'h9;
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk);
      #1;
      run_op('{ir: I_ADD, o: 32'h9, b: 32'h0, rdata: 32'h0, ack_at: 0, exp_stalls: 0, exp_reqs: 0, exp_d: 32'h0, exp_err: 1'b0}, stalls, reqs);
      chk("post_reset_add_o", o_out, 32'h9);
      chk("post_reset_add_ir", ir_out, I_ADD);

      // table-driven operations, issued back to back
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i], stalls, reqs);
         chk($sformatf("vec%0d_stalls", i), stalls, vecs[i].exp_stalls);
         chk($sformatf("vec%0d_reqs", i), reqs, vecs[i].exp_reqs);
         chk($sformatf("vec%0d_o_out", i), o_out, vecs[i].o);
         chk($sformatf("vec%0d_ir_out", i), ir_out, vecs[i].ir);
         chk($sformatf("vec%0d_d_out", i), d_out, vecs[i].exp_d);
         chk($sformatf("vec%0d_mem_err", i), {31'h0, mem_err}, {31'h0, vecs[i].exp_err});
         chk($sformatf("vec%0d_req_after", i), {31'h0, dmem_req}, 32'h0);
      end

      // a stray ack while idle must not disturb a pass-through op
      ir_in = I_ADD;
      o_in  = 32'h3C;
      step(1'b1, 32'hFFFF_FFFF, st);
      chk("idle_ack_d_out", d_out, 32'h0);
      chk("idle_ack_req", {31'h0, dmem_req}, 32'h0);

      chk("scoreboard_drained", sb.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, sitting directly downstream of the X/M pipeline register and feeding the M/W register. It decodes the instruction held in X/M, runs a request/acknowledge transaction with the data memory for `lw`/`sw`, stalls upstream stages until the transaction completes or times out, and registers the stage results into an internal M/W register for writeback.

## Interface
Parameters:
- `ADDR_W`, default 12: data-memory word-address width.
- `TIMEOUT`, default 15: maximum number of WAIT cycles before a transaction is aborted (≥1).

Ports:
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `clear`  in  1  asynchronous, active-low reset.
- `o_in`  in  32  ALU result from X/M; the memory address for `lw`/`sw`.
- `b_in`  in  32  rt value from X/M; the store data.
- `ir_in`  in  32  instruction from X/M.
- `dmem_req`  out  1  memory request, registered.
- `dmem_we`  out  1  write enable (1 = `sw`), registered.
- `dmem_addr`  out  ADDR_W  `o_in[ADDR_W-1:0]` captured at request start.
- `dmem_wdata`  out  32  `b_in` captured at request start.
- `dmem_rdata`  in  32  load data, valid while `dmem_ack` = 1.
- `dmem_ack`  in  1  completion strobe from memory.
- `stall`  out  1  combinational; holds PC, F/D, D/X and X/M when high.
- `o_out`  out  32  M/W ALU result.
- `d_out`  out  32  M/W load data.
- `ir_out`  out  32  M/W instruction.
- `mem_err`  out  1  sticky timeout flag.

## Operation
- Decode `ir_in[31:27]`: `OP_LW` = 5'b01000, `OP_SW` = 5'b00111. Anything else is a pass-through instruction.
- The FSM has two states.
- **IDLE**, pass-through instruction:
  - `stall` = 0.
  - At the edge, M/W loads `o_in`, `ir_in`, and `d_out` = 0.
- **IDLE**, `lw`/`sw`:
  - `stall` = 1.
  - At the edge, M/W loads a bubble (all three outputs = 0).
  - `dmem_req` ← 1, `dmem_we` ← (op == SW), and `dmem_addr`/`dmem_wdata` are captured.
  - The wait counter is cleared, and the FSM moves to WAIT.
- **WAIT**, `dmem_ack` = 1:
  - `stall` = 0.
  - At the edge, M/W loads `o_in` and `ir_in`.
  - `d_out` ← `dmem_rdata` for `lw`, 0 for `sw`.
  - `dmem_req`/`dmem_we` ← 0, and the FSM returns to IDLE.
  - X/M advances on the same edge.
- **WAIT**, `dmem_ack` = 0, counter < TIMEOUT-1:
  - `stall` = 1.
  - M/W loads a bubble, the counter increments, and the request is held stable.
- **WAIT**, `dmem_ack` = 0, counter == TIMEOUT-1 (abort):
  - `stall` = 0.
  - M/W loads `o_in`, `ir_in`, and `d_out` = 0.
  - `mem_err` ← 1, `dmem_req`/`dmem_we` ← 0, and the FSM moves to IDLE.
- `dmem_ack` in IDLE is ignored.
- `mem_err` is cleared only by reset.
- `dmem_addr` and `dmem_wdata` are stable for the whole request.
- Counter width is `$clog2(TIMEOUT)`, minimum 1 bit.

## Timing
- Reset (`clear` low, asynchronous):
  - State → IDLE and the counter → 0.
  - `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `o_out`, `d_out`, `ir_out` and `mem_err` all → 0.
  - `stall` then evaluates from IDLE.
- Reset during WAIT drops `dmem_req` immediately and abandons the transaction; no M/W write occurs.
- Pass-through latency: 1 cycle, X/M to M/W.
- Memory-op latency: 1 + k cycles, where k ≥ 1 is the number of WAIT cycles up to and including the ack.
  - Minimum is 2 cycles, when ack arrives in the first WAIT cycle.
- Stall length: k cycles for k WAIT cycles; the ack cycle itself is not stalled.
- Timeout: the request stays asserted for exactly TIMEOUT WAIT cycles.
  - An ack in the last of those cycles takes priority over the abort, and `mem_err` stays 0.
- Back-to-back memory ops: the ack edge returns the FSM to IDLE, the next op's IDLE cycle stalls, and `dmem_req` is low for exactly one cycle between transactions.
- The `dmem_ack` → `stall` path is combinational; memory must drive `dmem_ack` from a register.

## Structure
- Shared package `proc_pkg`:
  - `OP_LW`, `OP_SW`, `NOP` (32'h0).
  - FSM state typedef `mem_state_t` {IDLE, WAIT}.
- Sub-module `mw_reg`: the 3×32-bit M/W register.
  - Ports: `o_in`, `d_in`, `ir_in`, `o_out`, `d_out`, `ir_out`, `clk`, `clear`.
  - Built from the existing per-bit flip-flop cell.
  - `mem_stage` drives its inputs with the selected data or a bubble.
- The FSM, counter and request registers live in `mem_stage`.

## Test plan
- **Reset mid-WAIT:** `lw` issued and ack withheld for 3 cycles, then `clear` pulsed low → `dmem_req` = 0 immediately; all outputs 0; next `add` passes through normally.
- **Pass-through:** `ir_in` = add (opcode 0), `o_in` = 32'h5 → `stall` = 0; next cycle `o_out` = 5, `ir_out` = add, `d_out` = 0; `dmem_req` never rises.
- **Load, ack after 3 WAIT cycles:** `lw` with `o_in` = 32'h40, `dmem_rdata` = 32'hDEADBEEF → `dmem_addr` = 12'h040, `dmem_we` = 0, `stall` high for 1+2 cycles; `d_out` = DEADBEEF after the ack edge; 3 bubbles seen on `ir_out` before the load.
- **Store, ack in first WAIT cycle:** `sw` with `o_in` = 32'h10, `b_in` = 32'h1234 → `dmem_we` = 1, `dmem_wdata` = 1234, `stall` high for exactly 1 cycle; `ir_out` = sw, `d_out` = 0.
- **Timeout:** `lw` with no ack and TIMEOUT = 15 → `dmem_req` high for exactly 15 cycles, then `mem_err` = 1 and `d_out` = 0; `mem_err` still 1 after a later successful op.
- **Ack on the final cycle:** ack asserted in WAIT cycle 15 → normal completion and `mem_err` stays 0; a back-to-back `sw` afterwards shows exactly one `dmem_req`-low cycle between the two transactions.
